// File: rtl/logo_scroll_ctrl_pkg.sv
// logo_scroll_ctrl_pkg: shared coordinate constants and controller state encodings.
// Revision 1.0
`default_nettype none

package logo_scroll_ctrl_pkg;

  localparam int COORD_W = 11;
  localparam int LOGO_X0 = 500;
  localparam int LOGO_Y0 = 550;
  localparam int HOLD_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE_R = 3'd1,
    ST_HOLD_R = 3'd2,
    ST_MOVE_L = 3'd3,
    ST_HOLD_L = 3'd4
  } state_t;

  function automatic logic is_active(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: registered one-cycle pulse at the start of each vsync pulse.
// Revision 1.0
`default_nettype none

module vga_frame_tick #(
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_tick
);

  localparam logic VS_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic vs_hist;
  logic boundary;

  // Idle level in the previous cycle, sync level now.
  always_comb boundary = (vs_hist == VS_IDLE) && (vsync != VS_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_hist    <= VS_IDLE;
      frame_tick <= 1'b0;
    end else begin
      vs_hist    <= vsync;
      frame_tick <= boundary;
    end
  end

endmodule

`default_nettype wire

// File: rtl/logo_scroll_ctrl.sv
// logo_scroll_ctrl: per-frame bouncing horizontal offset for the logo painters.
// Revision 1.0
`default_nettype none

module logo_scroll_ctrl
  import logo_scroll_ctrl_pkg::*;
#(
  parameter int DELT_MAX      = 200,
  parameter int STEP          = 2,
  parameter int HOLD_FRAMES   = 60,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               start,
  input  logic               stop,
  output logic [COORD_W-1:0] delt,
  output logic               running,
  output logic               frame_tick
);

  localparam logic [COORD_W:0]   MAX_EXT   = (COORD_W+1)'(DELT_MAX);
  localparam logic [COORD_W:0]   STEP_EXT  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W-1:0] MAX_D     = COORD_W'(DELT_MAX);
  localparam logic [COORD_W-1:0] STEP_D    = COORD_W'(STEP);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_t              state, state_n;
  logic [COORD_W-1:0]  delt_n;
  logic                dir, dir_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [COORD_W:0]    sum_r;

  vga_frame_tick #(
    .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
  ) u_frame_tick (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      delt     <= '0;
      dir      <= 1'b0;
      hold_cnt <= '0;
      running  <= 1'b0;
    end else begin
      state    <= state_n;
      delt     <= delt_n;
      dir      <= dir_n;
      hold_cnt <= hold_cnt_n;
      running  <= is_active(state_n);
    end
  end

  always_comb begin
    state_n    = state;
    delt_n     = delt;
    dir_n      = dir;
    hold_cnt_n = hold_cnt;
    sum_r      = {1'b0, delt} + STEP_EXT;

    if (state == ST_IDLE) begin
      if (start && !stop) begin
        state_n    = dir ? ST_MOVE_L : ST_MOVE_R;
        hold_cnt_n = '0;
      end
    end else if (stop) begin
      // Clearing the counter makes a resumed hold serve its full dwell.
      state_n    = ST_IDLE;
      hold_cnt_n = '0;
    end else if (frame_tick) begin
      unique case (state)
        ST_MOVE_R: begin
          if (sum_r >= MAX_EXT) begin
            delt_n     = MAX_D;
            hold_cnt_n = '0;
            state_n    = ST_HOLD_R;
          end else begin
            delt_n = sum_r[COORD_W-1:0];
          end
        end
        ST_HOLD_R: begin
          if (hold_cnt == HOLD_LAST) begin
            state_n    = ST_MOVE_L;
            dir_n      = 1'b1;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
        ST_MOVE_L: begin
          if ({1'b0, delt} <= STEP_EXT) begin
            delt_n     = '0;
            hold_cnt_n = '0;
            state_n    = ST_HOLD_L;
          end else begin
            delt_n = delt - STEP_D;
          end
        end
        ST_HOLD_L: begin
          if (hold_cnt == HOLD_LAST) begin
            state_n    = ST_MOVE_R;
            dir_n      = 1'b0;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
        default: begin
          state_n    = ST_IDLE;
          hold_cnt_n = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logo_scroll_ctrl.sv
// tb_logo_scroll_ctrl: randomized scoreboard bench for two differently configured controllers.
// Revision 1.0
`default_nettype none

module tb_logo_scroll_ctrl;

  localparam int A_MAX = 201, A_STEP = 3, A_HOLD = 4;
  localparam int B_MAX = 20,  B_STEP = 2, B_HOLD = 2;
  localparam int N_CYCLES = 30000;

  logic clk = 1'b0;
  logic rst, vsync, start, stop;
  logic [10:0] delt_a, delt_b;
  logic run_a, run_b, tick_a, tick_b;

  always #5 clk = ~clk;

  logo_scroll_ctrl #(.DELT_MAX(A_MAX), .STEP(A_STEP), .HOLD_FRAMES(A_HOLD), .VS_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start), .stop(stop),
    .delt(delt_a), .running(run_a), .frame_tick(tick_a));

  logo_scroll_ctrl #(.DELT_MAX(B_MAX), .STEP(B_STEP), .HOLD_FRAMES(B_HOLD), .VS_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start), .stop(stop),
    .delt(delt_b), .running(run_b), .frame_tick(tick_b));

  typedef struct {
    bit run;
    bit dir;
    bit holding;
    int held;
    int delt;
    bit tick;
    bit vs_prev;
  } mdl_t;

  typedef struct {
    int delt;
    bit run;
    bit tick;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Behavioural model: one call advances one clock cycle.
  function automatic mdl_t mstep(mdl_t m, bit r, bit vs, bit st, bit sp,
                                 int dmax, int stp, int hold, bit alow);
    mdl_t n = m;
    if (r) begin
      n.run = 0; n.dir = 0; n.holding = 0; n.held = 0;
      n.delt = 0; n.tick = 0; n.vs_prev = alow;
      return n;
    end
    n.vs_prev = vs;
    n.tick    = alow ? (m.vs_prev && !vs) : (!m.vs_prev && vs);
    if (!m.run) begin
      if (st && !sp) begin
        n.run = 1; n.holding = 0; n.held = 0;
      end
    end else if (sp) begin
      n.run = 0; n.holding = 0; n.held = 0;
    end else if (m.tick) begin
      if (m.holding) begin
        if (m.held + 1 == hold) begin
          n.holding = 0; n.held = 0; n.dir = !m.dir;
        end else begin
          n.held = m.held + 1;
        end
      end else if (!m.dir) begin
        if (m.delt + stp >= dmax) begin
          n.delt = dmax; n.holding = 1; n.held = 0;
        end else begin
          n.delt = m.delt + stp;
        end
      end else begin
        if (m.delt <= stp) begin
          n.delt = 0; n.holding = 1; n.held = 0;
        end else begin
          n.delt = m.delt - stp;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: registered outputs are valid every cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("A.delt", int'(delt_a), e.delt);
        chk("A.running", int'(run_a), int'(e.run));
        chk("A.frame_tick", int'(tick_a), int'(e.tick));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("B.delt", int'(delt_b), e.delt);
        chk("B.running", int'(run_b), int'(e.run));
        chk("B.frame_tick", int'(tick_b), int'(e.tick));
      end
    end
  end

  // Driver: picks inputs at the falling edge and queues the model's post-edge outputs.
  initial begin
    mdl_t ma, mb;
    int   vs_left;
    bit   st, sp, r;
    rst = 1'b1; vsync = 1'b1; start = 1'b0; stop = 1'b0;
    ma = '{default: 0}; mb = '{default: 0};
    ma.vs_prev = 1'b1;
    vs_left = 8;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      if (vs_left == 0) begin
        vsync   = ~vsync;
        vs_left = vsync ? $urandom_range(6, 20) : $urandom_range(1, 3);
      end else begin
        vs_left--;
      end
      r  = (cyc < 3) || ($urandom_range(0, 5999) == 0);
      st = (cyc == 5) || ($urandom_range(0, 29) == 0);
      sp = ($urandom_range(0, 399) == 0) || (st && $urandom_range(0, 7) == 0);
      if (st && !sp && ((ma.run && ma.tick) || (mb.run && mb.tick)))
        st = 1'b0;
      rst = r; start = st; stop = sp;
      ma = mstep(ma, r, vsync, st, sp, A_MAX, A_STEP, A_HOLD, 1'b1);
      mb = mstep(mb, r, vsync, st, sp, B_MAX, B_STEP, B_HOLD, 1'b0);
      qa.push_back('{delt: ma.delt, run: ma.run, tick: ma.tick});
      qb.push_back('{delt: mb.delt, run: mb.run, tick: mb.tick});
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
